// File: rtl/wisc_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wisc_alu_pkg
// Description : Shared ALU definitions: control codes, default widths and the
//               flag-class decode used by the ALU arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package wisc_alu_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int CTRL_W_DEF = 4;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_NAND = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1100;
  localparam logic [3:0] ALU_SRL  = 4'b1110;
  localparam logic [3:0] ALU_SRA  = 4'b1111;

  // Arithmetic ops update Z/N/V; every other code (including undefined
  // ones) updates Z only.
  typedef enum logic [0:0] {
    FL_ARITH  = 1'b0,
    FL_Z_ONLY = 1'b1
  } flag_class_e;

  function automatic flag_class_e flag_class(input logic [3:0] op);
    return (op[3:2] == 2'b00) ? FL_ARITH : FL_Z_ONLY;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_arb_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin grant with the "served last" register.
//               Grant is combinational; last_q only moves on an accept.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               valid0/1     - request present
//               accept       - the granted request was accepted this cycle
//               gnt0/gnt1    - one-hot (or zero) grant
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic valid0,
  input  logic valid1,
  input  logic accept,
  output logic gnt0,
  output logic gnt1
);

  // last_q = 1 means requester 1 was served last, so requester 0 wins a tie.
  logic last_q;
  logic last_d;

  always_comb begin
    gnt0   = valid0 & (~valid1 | last_q);
    gnt1   = valid1 & (~valid0 | ~last_q);
    last_d = last_q;
    if (accept) begin
      last_d = gnt1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_arb.sv
`default_nettype none
// ============================================================================
// Module      : alu_arb
// Description : Shares one external 16-bit ALU between the execute stage
//               (port 0) and the address/branch-target unit (port 1).
//               Round-robin arbitration, combinational ALU drive, one-entry
//               registered response slot, architectural Z/N/V flags.
// Ports       : clk, rst               - clock, synchronous active-high reset
//               req{0,1}_*             - valid/ready request with op, a, b,
//                                        fl_en
//               alu_a/alu_b/alu_ctrl   - to ALU; alu_result/alu_{v,n,z} back
//               rsp_valid/rsp_ready    - response handshake; rsp_id,
//                                        rsp_result
//               flag_z/flag_n/flag_v   - architectural flag register
// Option      : ALU_ARB_PERF_EN adds perf_gnt0, perf_gnt1, perf_conflict
//               (16-bit saturating counters).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arb
  import wisc_alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CTRL_W-1:0] req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req0_fl_en,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CTRL_W-1:0] req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic              req1_fl_en,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_v,
  input  logic              alu_n,
  input  logic              alu_z,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
`ifdef ALU_ARB_PERF_EN
  output logic [15:0]       perf_gnt0,
  output logic [15:0]       perf_gnt1,
  output logic [15:0]       perf_conflict,
`endif
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_v
);

  logic              slot_free;
  logic              gnt0;
  logic              gnt1;
  logic              accept;
  logic              sel_fl_en;

  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              flag_z_q, flag_z_d;
  logic              flag_n_q, flag_n_d;
  logic              flag_v_q, flag_v_d;

  // The slot can take a new result if empty or being drained this cycle.
  assign slot_free  = ~rsp_valid_q | rsp_ready;
  assign req0_ready = gnt0 & slot_free;
  assign req1_ready = gnt1 & slot_free;
  assign accept     = req0_ready | req1_ready;

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst    (rst),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .accept (accept),
    .gnt0   (gnt0),
    .gnt1   (gnt1)
  );

  // Port 0 is the default mux leg, so the ALU sees defined values when idle.
  always_comb begin
    alu_a     = req0_a;
    alu_b     = req0_b;
    alu_ctrl  = req0_op;
    sel_fl_en = req0_fl_en;
    if (gnt1) begin
      alu_a     = req1_a;
      alu_b     = req1_b;
      alu_ctrl  = req1_op;
      sel_fl_en = req1_fl_en;
    end
  end

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    flag_z_d     = flag_z_q;
    flag_n_d     = flag_n_q;
    flag_v_d     = flag_v_q;
    if (accept) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = req1_ready;
      rsp_result_d = alu_result;
      if (sel_fl_en) begin
        flag_z_d = alu_z;
        if (flag_class(alu_ctrl[3:0]) == FL_ARITH) begin
          flag_n_d = alu_n;
          flag_v_d = alu_v;
        end
      end
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      flag_z_q     <= 1'b0;
      flag_n_q     <= 1'b0;
      flag_v_q     <= 1'b0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      flag_z_q     <= flag_z_d;
      flag_n_q     <= flag_n_d;
      flag_v_q     <= flag_v_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign flag_z     = flag_z_q;
  assign flag_n     = flag_n_q;
  assign flag_v     = flag_v_q;

`ifdef ALU_ARB_PERF_EN
  logic [15:0] perf_gnt0_q, perf_gnt0_d;
  logic [15:0] perf_gnt1_q, perf_gnt1_d;
  logic [15:0] perf_conflict_q, perf_conflict_d;

  // All counters stick at 16'hFFFF rather than wrapping.
  always_comb begin
    perf_gnt0_d     = perf_gnt0_q;
    perf_gnt1_d     = perf_gnt1_q;
    perf_conflict_d = perf_conflict_q;
    if (req0_ready && (perf_gnt0_q != 16'hFFFF)) begin
      perf_gnt0_d = perf_gnt0_q + 16'd1;
    end
    if (req1_ready && (perf_gnt1_q != 16'hFFFF)) begin
      perf_gnt1_d = perf_gnt1_q + 16'd1;
    end
    if (req0_valid && req1_valid && slot_free && (perf_conflict_q != 16'hFFFF)) begin
      perf_conflict_d = perf_conflict_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_gnt0_q     <= '0;
      perf_gnt1_q     <= '0;
      perf_conflict_q <= '0;
    end else begin
      perf_gnt0_q     <= perf_gnt0_d;
      perf_gnt1_q     <= perf_gnt1_d;
      perf_conflict_q <= perf_conflict_d;
    end
  end

  assign perf_gnt0     = perf_gnt0_q;
  assign perf_gnt1     = perf_gnt1_q;
  assign perf_conflict = perf_conflict_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arb
// Description : Self-checking bench for alu_arb. Models the external ALU,
//               applies a vector table plus reset/tie/perf sequences, and
//               checks responses through a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arb;

  localparam logic [3:0] C_ADD  = 4'b0000;
  localparam logic [3:0] C_NAND = 4'b0100;
  localparam logic [3:0] C_XOR  = 4'b1000;
  localparam logic [3:0] C_SLL  = 4'b1100;
  localparam logic [3:0] C_SRL  = 4'b1110;
  localparam logic [3:0] C_SRA  = 4'b1111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_op = '0, req1_op = '0;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_fl_en = 1'b0, req1_fl_en = 1'b0;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_ctrl;
  logic        alu_v, alu_n, alu_z;
  logic        rsp_valid, rsp_id;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic        flag_z, flag_n, flag_v;
`ifdef ALU_ARB_PERF_EN
  logic [15:0] perf_gnt0, perf_gnt1, perf_conflict;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_arb dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_fl_en (req0_fl_en),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_fl_en (req1_fl_en),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_v      (alu_v),
    .alu_n      (alu_n),
    .alu_z      (alu_z),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
`ifdef ALU_ARB_PERF_EN
    .perf_gnt0     (perf_gnt0),
    .perf_gnt1     (perf_gnt1),
    .perf_conflict (perf_conflict),
`endif
    .flag_z     (flag_z),
    .flag_n     (flag_n),
    .flag_v     (flag_v)
  );

  // Reference ALU: result and flags for an op/operand pair.
  function automatic logic [18:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    logic [15:0] r;
    logic        v;
    r = 16'h0000;
    v = 1'b0;
    case (op)
      C_ADD:  begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
      C_NAND: r = ~(a & b);
      C_XOR:  r = a ^ b;
      C_SLL:  r = a << b[3:0];
      C_SRL:  r = a >> b[3:0];
      C_SRA:  r = $unsigned($signed(a) >>> b[3:0]);
      default: r = 16'h0000;
    endcase
    return {v, r[15], (r == 16'h0000), r};
  endfunction

  always_comb begin
    {alu_v, alu_n, alu_z, alu_result} = alu_f(alu_ctrl, alu_a, alu_b);
  end

  typedef struct {
    logic        v0;
    logic [3:0]  op0;
    logic [15:0] a0, b0;
    logic        fl0;
    logic        v1;
    logic [3:0]  op1;
    logic [15:0] a1, b1;
    logic        fl1;
    logic        rr;
    logic        er0, er1;
  } vec_t;

  typedef struct packed {
    logic        id;
    logic [15:0] res;
    logic        z, n, v;
  } sb_t;

  sb_t sb[$];

  // Bench-side view of architectural state.
  logic        m_rv, m_id, m_z, m_n, m_v;
  logic [15:0] m_res;

  function automatic vec_t mk(input logic v0, input logic [3:0] op0, input logic [15:0] a0,
                              input logic [15:0] b0, input logic fl0, input logic v1,
                              input logic [3:0] op1, input logic [15:0] a1, input logic [15:0] b1,
                              input logic fl1, input logic rr, input logic er0, input logic er1);
    vec_t t;
    t.v0 = v0; t.op0 = op0; t.a0 = a0; t.b0 = b0; t.fl0 = fl0;
    t.v1 = v1; t.op1 = op1; t.a1 = a1; t.b1 = b1; t.fl1 = fl1;
    t.rr = rr; t.er0 = er0; t.er1 = er1;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_model();
    m_rv = 1'b0; m_id = 1'b0; m_res = 16'h0000;
    m_z = 1'b0; m_n = 1'b0; m_v = 1'b0;
    sb.delete();
  endtask

  // One request cycle: drive, check readies mid-cycle, check response after edge.
  task automatic run_vec(input vec_t t, input string nm);
    logic        acc, id, fl;
    logic [3:0]  op;
    logic [15:0] a, b, r;
    logic        z, n, v;
    sb_t         e;
    req0_valid = t.v0; req0_op = t.op0; req0_a = t.a0; req0_b = t.b0; req0_fl_en = t.fl0;
    req1_valid = t.v1; req1_op = t.op1; req1_a = t.a1; req1_b = t.b1; req1_fl_en = t.fl1;
    rsp_ready  = t.rr;
    @(negedge clk);
    chk({nm, " req0_ready"}, {31'd0, req0_ready}, {31'd0, t.er0});
    chk({nm, " req1_ready"}, {31'd0, req1_ready}, {31'd0, t.er1});
    if (!t.v0 && !t.v1) begin
      chk({nm, " idle alu_a"}, {16'd0, alu_a}, {16'd0, t.a0});
    end
    acc = t.er0 | t.er1;
    id  = t.er1;
    if (acc) begin
      op = id ? t.op1 : t.op0;
      a  = id ? t.a1 : t.a0;
      b  = id ? t.b1 : t.b0;
      fl = id ? t.fl1 : t.fl0;
      {v, n, z, r} = alu_f(op, a, b);
      if (fl) begin
        m_z = z;
        if (op[3:2] == 2'b00) begin
          m_n = n;
          m_v = v;
        end
      end
      sb.push_back('{id: id, res: r, z: m_z, n: m_n, v: m_v});
    end
    @(posedge clk);
    #1;
    if (acc) begin
      e = sb.pop_front();
      chk({nm, " rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({nm, " rsp_id"}, {31'd0, rsp_id}, {31'd0, e.id});
      chk({nm, " rsp_result"}, {16'd0, rsp_result}, {16'd0, e.res});
      chk({nm, " flags"}, {29'd0, flag_z, flag_n, flag_v}, {29'd0, e.z, e.n, e.v});
      m_rv = 1'b1; m_id = e.id; m_res = e.res;
    end else if (t.rr || !m_rv) begin
      chk({nm, " rsp_valid low"}, {31'd0, rsp_valid}, 32'd0);
      chk({nm, " flags hold"}, {29'd0, flag_z, flag_n, flag_v}, {29'd0, m_z, m_n, m_v});
      m_rv = 1'b0;
    end else begin
      chk({nm, " stall rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({nm, " stall rsp_id"}, {31'd0, rsp_id}, {31'd0, m_id});
      chk({nm, " stall rsp_result"}, {16'd0, rsp_result}, {16'd0, m_res});
      chk({nm, " stall flags"}, {29'd0, flag_z, flag_n, flag_v}, {29'd0, m_z, m_n, m_v});
    end
  endtask

  task automatic do_reset(input string nm);
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
    chk({nm, " rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({nm, " rsp_id"}, {31'd0, rsp_id}, 32'd0);
    chk({nm, " rsp_result"}, {16'd0, rsp_result}, 32'd0);
    chk({nm, " flags"}, {29'd0, flag_z, flag_n, flag_v}, 32'd0);
  endtask

  vec_t tbl[19];
  vec_t tie0, tie1, only0, only1, stall0;

  initial begin
    // v0 op0 a0 b0 fl0 | v1 op1 a1 b1 fl1 | rsp_ready | exp ready0 ready1
    tbl[0]  = mk(1, C_ADD,  16'h7FFF, 16'h0001, 1, 0, C_ADD,  16'h0000, 16'h0000, 0, 1, 1, 0);
    tbl[1]  = mk(1, C_ADD,  16'h0001, 16'h0001, 0, 1, C_ADD,  16'h0002, 16'h0003, 0, 1, 0, 1);
    tbl[2]  = mk(1, C_ADD,  16'h0001, 16'h0001, 0, 1, C_ADD,  16'h0002, 16'h0003, 0, 1, 1, 0);
    tbl[3]  = mk(1, C_ADD,  16'h0001, 16'h0001, 0, 1, C_ADD,  16'h0002, 16'h0003, 0, 0, 0, 0);
    tbl[4]  = tbl[3];
    tbl[5]  = tbl[3];
    tbl[6]  = mk(1, C_ADD,  16'h0001, 16'h0001, 0, 1, C_ADD,  16'h0002, 16'h0003, 0, 1, 0, 1);
    tbl[7]  = mk(1, C_XOR,  16'h1234, 16'h1234, 1, 0, C_ADD,  16'h0000, 16'h0000, 0, 1, 1, 0);
    tbl[8]  = mk(0, C_ADD,  16'h0000, 16'h0000, 0, 1, C_XOR,  16'h1234, 16'h1234, 0, 1, 0, 1);
    tbl[9]  = mk(1, C_ADD,  16'h0001, 16'h0001, 1, 0, C_ADD,  16'h0000, 16'h0000, 0, 1, 1, 0);
    tbl[10] = mk(0, C_ADD,  16'h0000, 16'h0000, 0, 1, C_NAND, 16'hFFFF, 16'hFFFF, 1, 1, 0, 1);
    tbl[11] = mk(0, C_ADD,  16'h0000, 16'h0000, 0, 1, C_SRA,  16'h8000, 16'h0004, 1, 1, 0, 1);
    tbl[12] = mk(0, C_ADD,  16'h5A5A, 16'h0000, 0, 0, C_ADD,  16'h0000, 16'h0000, 0, 1, 0, 0);
    tbl[13] = mk(1, C_ADD,  16'h8000, 16'h8000, 1, 0, C_ADD,  16'h0000, 16'h0000, 0, 1, 1, 0);
    tbl[14] = mk(1, C_SLL,  16'h0001, 16'h000F, 1, 0, C_ADD,  16'h0000, 16'h0000, 0, 1, 1, 0);
    tbl[15] = mk(0, C_ADD,  16'h0000, 16'h0000, 0, 1, C_SRL,  16'h8000, 16'h000F, 1, 1, 0, 1);
    tbl[16] = mk(0, C_ADD,  16'h0000, 16'h0000, 0, 1, C_ADD,  16'h1111, 16'h2222, 1, 0, 0, 0);
    tbl[17] = mk(0, C_ADD,  16'h0000, 16'h0000, 0, 0, C_ADD,  16'h0000, 16'h0000, 0, 1, 0, 0);
    tbl[18] = tbl[17];

    tie0   = mk(1, C_ADD, 16'h0010, 16'h0001, 1, 1, C_XOR, 16'h00F0, 16'h000F, 1, 1, 1, 0);
    tie1   = mk(1, C_ADD, 16'h0010, 16'h0001, 1, 1, C_XOR, 16'h00F0, 16'h000F, 1, 1, 0, 1);
    only0  = mk(1, C_ADD, 16'h0003, 16'h0004, 0, 0, C_ADD, 16'h0000, 16'h0000, 0, 1, 1, 0);
    only1  = mk(0, C_ADD, 16'h0000, 16'h0000, 0, 1, C_SLL, 16'h0003, 16'h0002, 0, 1, 0, 1);
    stall0 = mk(1, C_ADD, 16'h7FFF, 16'h0001, 1, 0, C_ADD, 16'h0000, 16'h0000, 0, 0, 0, 0);

    @(posedge clk);
    do_reset("reset");

    for (int i = 0; i < 19; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset while a response is stalled: slot and flags clear, tie goes to req0.
    run_vec(mk(1, C_ADD, 16'h7FFF, 16'h0001, 1, 0, C_ADD, 16'h0000, 16'h0000, 0, 0, 1, 0),
            "pre_stall");
    run_vec(stall0, "mid_stall");
    do_reset("rst_mid_stall");
    run_vec(tie0, "tie_a");
    run_vec(tie1, "tie_b");
    run_vec(tie0, "tie_c");
    run_vec(tie1, "tie_d");

    do_reset("rst_perf");
    run_vec(tie0, "perf_t0");
    run_vec(tie1, "perf_t1");
    for (int i = 0; i < 4; i++) run_vec(only0, $sformatf("perf_r0_%0d", i));
    for (int i = 0; i < 2; i++) run_vec(only1, $sformatf("perf_r1_%0d", i));
`ifdef ALU_ARB_PERF_EN
    chk("perf_gnt0", {16'd0, perf_gnt0}, 32'd5);
    chk("perf_gnt1", {16'd0, perf_gnt1}, 32'd3);
    chk("perf_conflict", {16'd0, perf_conflict}, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/alu_arb.md
Name: alu_arb

Overview:
- Shares the single 16-bit ALU between two requesters: port 0 is the execute stage, port 1 is the address/branch-target calculation.
- Round-robin arbitration with valid/ready handshakes.
- Drives the ALU combinationally and captures its result into a one-entry registered response slot.
- Owns the architectural Z/N/V flag register and updates it per operation class.

Parameters:
- DATA_W, 16, operand/result width
- CTRL_W, 4, ALU control code width

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-high
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_op / req1_op  in  CTRL_W  ALU control code
- req0_a, req0_b / req1_a, req1_b  in  DATA_W  operands
- req0_fl_en / req1_fl_en  in  1  request may update flags
- alu_a, alu_b  out  DATA_W  to ALU operand inputs
- alu_ctrl  out  CTRL_W  to ALU control
- alu_result  in  DATA_W  from ALU
- alu_v, alu_n, alu_z  in  1  ALU flag outputs
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  requester that produced the response
- rsp_result  out  DATA_W  registered result
- flag_z, flag_n, flag_v  out  1  architectural flag register

Behaviour:
- Slot free: slot_free = ~rsp_valid | rsp_ready.
- Grant is combinational:
  - Only one valid: that requester is granted.
  - Both valid: the requester not served last is granted.
  - rr_last resets to 1, so req0 wins the first tie.
- reqN_ready = grant_N & slot_free. At most one ready high per cycle.
- ALU mux: alu_a/alu_b/alu_ctrl carry the granted requester's fields. With no valid request they carry req0 fields; the values are don't-care but must not be X.
- Accept edge (valid & ready):
  - rsp_result <= alu_result; rsp_id <= N; rsp_valid <= 1; rr_last <= N.
  - Latency: 1 cycle from accept to rsp_valid.
  - Throughput: 1 response per cycle when rsp_ready is held high.
- Stall: rsp_valid & ~rsp_ready holds rsp_* and all flags stable and keeps both ready signals low.
- No accept with rsp_ready high: rsp_valid <= 0.
- Flag update on accept with fl_en=1:
  - Arithmetic class (op[3:2]==2'b00): Z, N and V all take the alu_* values.
  - All other codes (NAND 0100, XOR 1000, SLL 1100, SRL 1110, SRA 1111, undefined): Z only; N and V hold.
  - fl_en=0: no flag change.
  - Flags change on the same edge rsp_valid rises.
- Request rules:
  - Requesters hold valid/op/operands stable until ready.
  - Dropping valid before ready is legal; that request is not served.
- Reset: rsp_valid=0, rsp_id=0, rsp_result=0, flags=0, rr_last=1, counters=0. A held response is discarded; requesters must re-present.
- Starvation: bounded; with both valid continuously, each requester is served every 2 accepts.

Optional Feature:
- Macro: ALU_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_gnt0 and perf_gnt1 (16 bit), counting accepts per requester.
  - Adds perf_conflict (16 bit), counting cycles with both valid and a free slot.
  - All three saturate at 16'hFFFF and clear on rst.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Shared package wisc_alu_pkg:
  - ALU control code constants: ADD 4'b0000, NAND 4'b0100, XOR 4'b1000, SLL 4'b1100, SRL 4'b1110, SRA 4'b1111.
  - Flag-class decode function.
  - DATA_W / CTRL_W defaults.
- Sub-module: one, rr_arb2 (2-way round-robin grant plus rr_last state). The ALU itself stays external.

Test Plan:
- Single request: req0 valid ADD a=16'h7FFF b=16'h0001, fl_en=1, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_result=16'h8000, Z=0, N=1, V=1.
- Tie after reset: both valid every cycle, rsp_ready=1 -> rsp_id sequence 0,1,0,1; each ready asserted alternately.
- Backpressure: rsp_ready=0 for 3 cycles after a response -> rsp_result held, both ready=0, flags unchanged; rsp_ready=1 -> next request accepted same cycle.
- Flag classes: XOR a=b=16'h1234, fl_en=1, after prior ADD set N=1,V=1 -> Z=1, N=1, V=1 unchanged. Repeat with fl_en=0 -> no flag change.
- Reset mid-stall: rsp_valid=1, rsp_ready=0, assert rst one cycle -> rsp_valid=0, flags=0, next tie grants req0.
- ALU_ARB_PERF_EN defined: 5 req0 and 3 req1 accepts, 2 conflict cycles -> perf_gnt0=5, perf_gnt1=3, perf_conflict=2.
